// File: rtl/rrs_pkg.sv
// rrs_decim shared types and sizing.
// Sample format, FSM states and FIFO geometry.
package rrs_pkg;

  localparam int width_H   = 5;
  localparam int width_W   = 20;
  localparam int R         = 8;
  localparam int log_R     = 3;
  localparam int DEPTH     = 4;
  localparam int log_DEPTH = 2;
  localparam int WARMUP    = 40;

  localparam int SAMPLE_W  = width_H + width_W;
  localparam int WARM_W    = $clog2(WARMUP + 1);
  localparam int PTR_W     = log_DEPTH + 1;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [log_R-1:0]    phase_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  typedef enum logic [0:0] {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rrs_fifo.sv
// First-word-fall-through sample FIFO.
// Head is shown directly; last popped value is held when empty.
module rrs_fifo
  import rrs_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  sample_t din,
  output logic    full,
  input  logic    pop,
  output sample_t dout,
  output logic    empty
);

  sample_t mem_q [DEPTH];
  sample_t mem_d [DEPTH];
  ptr_t    wr_q, wr_d;
  ptr_t    rd_q, rd_d;
  sample_t last_q, last_d;

  logic do_pop;
  logic do_push;
  logic [log_DEPTH-1:0] wr_idx;
  logic [log_DEPTH-1:0] rd_idx;

  // Status, accepted push/pop and next pointer/storage state.
  always_comb begin
    wr_idx  = wr_q[log_DEPTH-1:0];
    rd_idx  = rd_q[log_DEPTH-1:0];
    empty   = (wr_q == rd_q);
    full    = (wr_q[log_DEPTH] != rd_q[log_DEPTH])
           && (wr_idx == rd_idx);
    do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push needs.
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_idx] = din;
    end
    wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + PTR_W'(1) : rd_q;
    last_d  = do_pop  ? mem_q[rd_idx] : last_q;
    dout    = empty   ? last_q : mem_q[rd_idx];
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rrs_decim.sv
// Warm-up discard and decimate-by-R stage.
// Kept samples go to a FWFT FIFO; overflow is sticky.
module rrs_decim
  import rrs_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_i_en,
  input  logic [width_H+width_W-1:0]    data_i,
  input  logic [log_R-1:0]              phase_i,
  output logic                          data_o_valid,
  input  logic                          data_o_ready,
  output logic [width_H+width_W-1:0]    data_o,
  output logic                          overflow_o
);

  state_t              state_q, state_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  phase_t              phase_q, phase_d;
  logic                ovf_q, ovf_d;

  logic    keep;
  logic    full;
  logic    empty;
  sample_t dout;

  // Warm-up counting, phase tracking and keep decision.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    phase_d = phase_q;
    keep    = 1'b0;
    if (data_i_en) begin
      unique case (state_q)
        WARM: begin
          if (warm_q == WARM_W'(WARMUP - 1)) begin
            state_d = RUN;
            phase_d = '0;
          end else begin
            warm_d = warm_q + WARM_W'(1);
          end
        end
        RUN: begin
          keep    = (phase_q == phase_i);
          phase_d = phase_q + log_R'(1);
        end
        default: state_d = WARM;
      endcase
    end
  end

  // Overflow latches when a kept sample meets a full FIFO without a pop.
  always_comb begin
    ovf_d = ovf_q | (keep && full && !data_o_ready);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WARM;
      warm_q  <= '0;
      phase_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
    end
  end

  rrs_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .din   (data_i),
    .full  (full),
    .pop   (data_o_ready),
    .dout  (dout),
    .empty (empty)
  );

  assign data_o_valid = !empty;
  assign data_o       = dout;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_rrs_decim.sv
// Self-checking bench for rrs_decim.
// Queue-based reference model of warm-up, decimation and FIFO.
module tb_rrs_decim;
  import rrs_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    en;
  sample_t din;
  logic [log_R-1:0] ph;
  logic    data_o_valid;
  logic    ready;
  sample_t data_o;
  logic    overflow_o;

  int tests = 0;
  int fails = 0;

  sample_t mq[$];
  sample_t seen[$];
  sample_t m_last;
  bit      m_ovf;
  int      n_en;

  always #5 clk = ~clk;

  rrs_decim dut (
    .clk          (clk),
    .rst          (rst),
    .data_i_en    (en),
    .data_i       (din),
    .phase_i      (ph),
    .data_o_valid (data_o_valid),
    .data_o_ready (ready),
    .data_o       (data_o),
    .overflow_o   (overflow_o)
  );

  // One clock: advance the reference model with the driven inputs.
  task automatic tick();
    bit kept;
    bit pop;
    kept = !rst && en && (n_en >= WARMUP)
        && (((n_en - WARMUP) % R) == int'(ph));
    pop  = !rst && ready && (mq.size() > 0);
    if (!rst && data_o_valid && ready) seen.push_back(data_o);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      n_en   = 0;
    end else begin
      if (en) n_en++;
      if (pop) m_last = mq.pop_front();
      if (kept) begin
        if (mq.size() < DEPTH) mq.push_back(din);
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
    seen.delete();
  endtask

  task automatic test_reset();
    do_reset(2);
    tests++;
    if (data_o_valid !== 1'b0 || data_o !== '0 || overflow_o !== 1'b0) begin
      fails++;
      $display("FAIL reset: valid=%b data=%h ovf=%b want 0/0/0",
               data_o_valid, data_o, overflow_o);
    end
  endtask

  task automatic test_decim(input string nm, input int p, input int gap);
    sample_t exp_d;
    sample_t want[$];
    ph    = 3'(p);
    ready = 1'b1;
    do_reset(2);
    for (int k = 0; k < 72; k++) begin
      for (int g = 0; g <= gap; g++) begin
        en  = (g == 0);
        din = sample_t'(k);
        tick();
        exp_d = (mq.size() > 0) ? mq[0] : m_last;
        tests++;
        if (data_o_valid !== (mq.size() > 0) || data_o !== exp_d) begin
          fails++;
          $display("FAIL %s k=%0d: valid=%b data=%h want %b/%h",
                   nm, k, data_o_valid, data_o, mq.size() > 0, exp_d);
        end
      end
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 4; i++) want.push_back(sample_t'(40 + p + 8 * i));
    tests++;
    if (seen != want) begin
      fails++;
      $display("FAIL %s seq: got %p want %p", nm, seen, want);
    end
  endtask

  task automatic test_overflow();
    sample_t exp_d;
    sample_t want[$];
    ph    = '0;
    ready = 1'b0;
    do_reset(1);
    for (int k = 0; k < 80; k++) begin
      en  = 1'b1;
      din = sample_t'(k);
      tick();
      exp_d = (mq.size() > 0) ? mq[0] : m_last;
      tests++;
      if (data_o_valid !== (mq.size() > 0) || data_o !== exp_d
          || overflow_o !== m_ovf) begin
        fails++;
        $display("FAIL ovf k=%0d: v=%b d=%h o=%b want %b/%h/%b",
                 k, data_o_valid, data_o, overflow_o,
                 mq.size() > 0, exp_d, m_ovf);
      end
    end
    en    = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    want = '{sample_t'(40), sample_t'(48), sample_t'(56), sample_t'(64)};
    tests++;
    if (seen != want || data_o_valid !== 1'b0 || overflow_o !== 1'b1) begin
      fails++;
      $display("FAIL ovf drain: got %p v=%b o=%b want %p v=0 o=1",
               seen, data_o_valid, overflow_o, want);
    end
  endtask

  task automatic test_full_pop_push();
    sample_t want[$];
    ph    = '0;
    ready = 1'b0;
    do_reset(1);
    for (int k = 0; k < 80; k++) begin
      en    = 1'b1;
      din   = sample_t'(k);
      ready = (k >= 72);
      tick();
      tests++;
      if (data_o_valid !== (mq.size() > 0) || overflow_o !== m_ovf) begin
        fails++;
        $display("FAIL fullpp k=%0d: v=%b o=%b want %b/%b",
                 k, data_o_valid, overflow_o, mq.size() > 0, m_ovf);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 5; i++) want.push_back(sample_t'(40 + 8 * i));
    tests++;
    if (seen != want || overflow_o !== 1'b0) begin
      fails++;
      $display("FAIL fullpp seq: got %p o=%b want %p o=0",
               seen, overflow_o, want);
    end
  endtask

  task automatic test_negative();
    sample_t neg40;
    ph    = '0;
    ready = 1'b1;
    do_reset(1);
    for (int k = 0; k < 50; k++) begin
      en  = 1'b1;
      din = sample_t'(-k);
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    neg40 = 25'h1FFFFD8;
    tests++;
    if (seen.size() != 2 || seen[0] !== neg40
        || seen[1] !== sample_t'(-48)) begin
      fails++;
      $display("FAIL negative: got %p want %h,%h",
               seen, neg40, sample_t'(-48));
    end
  endtask

  task automatic test_mid_reset();
    sample_t want;
    ph    = '0;
    ready = 1'b0;
    do_reset(1);
    for (int k = 0; k < 49; k++) begin
      en  = 1'b1;
      din = sample_t'(k);
      tick();
    end
    tests++;
    if (mq.size() != 2 || data_o_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrst pre: v=%b want 1 (model %0d queued)",
               data_o_valid, mq.size());
    end
    do_reset(1);
    tests++;
    if (data_o_valid !== 1'b0 || data_o !== '0 || overflow_o !== 1'b0) begin
      fails++;
      $display("FAIL midrst: v=%b d=%h o=%b want 0/0/0",
               data_o_valid, data_o, overflow_o);
    end
    ready = 1'b1;
    for (int j = 0; j < 41; j++) begin
      en  = 1'b1;
      din = sample_t'(1000 + j);
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    want = sample_t'(1040);
    tests++;
    if (seen.size() != 1 || seen[0] !== want) begin
      fails++;
      $display("FAIL midrst out: got %p want %h", seen, want);
    end
  endtask

  task automatic test_random();
    sample_t exp_d;
    ph    = 3'($urandom);
    ready = 1'b1;
    do_reset(1);
    for (int c = 0; c < 1500; c++) begin
      en    = ($urandom_range(3) != 0);
      din   = sample_t'($urandom);
      ready = ($urandom_range(7) < 5);
      if ($urandom_range(99) == 0) ph = 3'($urandom);
      tick();
      exp_d = (mq.size() > 0) ? mq[0] : m_last;
      tests++;
      if (data_o_valid !== (mq.size() > 0) || data_o !== exp_d
          || overflow_o !== m_ovf) begin
        fails++;
        $display("FAIL random c=%0d: v=%b d=%h o=%b want %b/%h/%b",
                 c, data_o_valid, data_o, overflow_o,
                 mq.size() > 0, exp_d, m_ovf);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    din   = '0;
    ph    = '0;
    ready = 1'b1;
    m_last = '0;
    m_ovf  = 1'b0;
    n_en   = 0;
    #1;
    test_reset();
    test_decim("phase0", 0, 0);
    test_decim("phase3", 3, 0);
    test_decim("phase3gap", 3, 2);
    test_overflow();
    test_full_pop_push();
    test_negative();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
